// File: rtl/sparc_pkg.sv
// Shared fetch-path definitions: next-PC select codes,
// the bubble instruction word and the fetch FSM states.
package sparc_pkg;

  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JMPL   = 2'b10;

  localparam logic [31:0] NOP_INSTR = 32'h0;

  typedef enum logic {
    BOOT,
    RUN
  } fetch_state_e;

endpackage

// File: rtl/pc_npc_register.sv
// SPARC PC/nPC pair with delayed-branch update, +4 adder,
// target mux with word-alignment masking and a misalign flag.
// Ports: clk, reset (async high), le (load enable),
//   pc_sel, branch_target, jmpl_target -> pc_out, npc_out,
//   misalign (registered).
module pc_npc_register
  import sparc_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              le,
  input  logic [1:0]        pc_sel,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic [ADDR_W-1:0] jmpl_target,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] npc_out,
  output logic              misalign
);

  localparam logic [ADDR_W-1:0] RESET_NPC =
    RESET_PC + ADDR_W'(4);

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_npc;
  logic              r_mis;

  logic [ADDR_W-1:0] w_seq;
  logic [ADDR_W-1:0] w_next;
  logic              w_mis;

  // Reserved select 11 falls back to sequential.
  always_comb begin
    w_seq  = r_npc + ADDR_W'(4);
    w_next = w_seq;
    w_mis  = 1'b0;
    unique case (pc_sel)
      PC_BRANCH: begin
        w_next = {branch_target[ADDR_W-1:2], 2'b00};
        w_mis  = |branch_target[1:0];
      end
      PC_JMPL: begin
        w_next = {jmpl_target[ADDR_W-1:2], 2'b00};
        w_mis  = |jmpl_target[1:0];
      end
      PC_SEQ:  w_next = w_seq;
      default: w_next = w_seq;
    endcase
  end

  // Delayed branch: PC always takes the old nPC.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc  <= RESET_PC;
      r_npc <= RESET_NPC;
      r_mis <= 1'b0;
    end else if (le) begin
      r_pc  <= r_npc;
      r_npc <= w_next;
      r_mis <= w_mis;
    end
  end

  assign pc_out   = r_pc;
  assign npc_out  = r_npc;
  assign misalign = r_mis;

endmodule

// File: rtl/fetch_if_id_stage.sv
// Instruction fetch stage plus IF/ID pipeline register.
// Ports: clk, reset (async high), le, pc_sel,
//   branch_target, jmpl_target, annul, instr_in ->
//   pc_out, npc_out, if_id_instr/pc/npc/valid, misalign.
// Macro FETCH_COUNT_EN adds fetch_count (valid loads).
module fetch_if_id_stage
  import sparc_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              le,
  input  logic [1:0]        pc_sel,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic [ADDR_W-1:0] jmpl_target,
  input  logic              annul,
  input  logic [31:0]       instr_in,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] npc_out,
  output logic [31:0]       if_id_instr,
  output logic [ADDR_W-1:0] if_id_pc,
  output logic [ADDR_W-1:0] if_id_npc,
  output logic              if_id_valid,
`ifdef FETCH_COUNT_EN
  output logic [31:0]       fetch_count,
`endif
  output logic              misalign
);

  logic [ADDR_W-1:0] w_pc;
  logic [ADDR_W-1:0] w_npc;

  fetch_state_e      r_state;
  logic [31:0]       r_instr;
  logic [ADDR_W-1:0] r_ipc;
  logic [ADDR_W-1:0] r_inpc;
  logic              r_valid;

  pc_npc_register #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk           (clk),
    .reset         (reset),
    .le            (le),
    .pc_sel        (pc_sel),
    .branch_target (branch_target),
    .jmpl_target   (jmpl_target),
    .pc_out        (w_pc),
    .npc_out       (w_npc),
    .misalign      (misalign)
  );

  // IF/ID captures the word addressed by the current PC.
  // Annul squashes the word but keeps its PC/nPC tags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= BOOT;
      r_instr <= NOP_INSTR;
      r_ipc   <= '0;
      r_inpc  <= '0;
      r_valid <= 1'b0;
    end else if (le) begin
      r_ipc   <= w_pc;
      r_inpc  <= w_npc;
      r_instr <= annul ? NOP_INSTR : instr_in;
      r_valid <= ~annul;
      unique case (r_state)
        BOOT: r_state <= RUN;
        RUN:  r_state <= RUN;
      endcase
    end
  end

`ifdef FETCH_COUNT_EN
  logic [31:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (le && !annul) begin
      r_cnt <= r_cnt + 32'd1;
    end
  end

  assign fetch_count = r_cnt;
`endif

  assign pc_out      = w_pc;
  assign npc_out     = w_npc;
  assign if_id_instr = r_instr;
  assign if_id_pc    = r_ipc;
  assign if_id_npc   = r_inpc;
  assign if_id_valid = r_valid;

endmodule

// File: tb/tb_fetch_if_id_stage.sv
// Self-checking bench for fetch_if_id_stage against a
// behavioural PC/nPC + IF/ID reference model.
module tb_fetch_if_id_stage;

  logic        clk;
  logic        reset;
  logic        le;
  logic [1:0]  pc_sel;
  logic [31:0] branch_target;
  logic [31:0] jmpl_target;
  logic        annul;
  logic [31:0] instr_in;
  logic [31:0] pc_out;
  logic [31:0] npc_out;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_npc;
  logic        if_id_valid;
  logic        misalign;
`ifdef FETCH_COUNT_EN
  logic [31:0] fetch_count;
`endif

  int tests = 0;
  int fails = 0;

  // reference model state
  logic [31:0] m_pc, m_npc, m_ii, m_ipc, m_inpc, m_cnt;
  logic        m_v, m_mis;

  fetch_if_id_stage dut (
    .clk           (clk),
    .reset         (reset),
    .le            (le),
    .pc_sel        (pc_sel),
    .branch_target (branch_target),
    .jmpl_target   (jmpl_target),
    .annul         (annul),
    .instr_in      (instr_in),
    .pc_out        (pc_out),
    .npc_out       (npc_out),
    .if_id_instr   (if_id_instr),
    .if_id_pc      (if_id_pc),
    .if_id_npc     (if_id_npc),
    .if_id_valid   (if_id_valid),
`ifdef FETCH_COUNT_EN
    .fetch_count   (fetch_count),
`endif
    .misalign      (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [193:0] dut_v();
    logic [31:0] c;
`ifdef FETCH_COUNT_EN
    c = fetch_count;
`else
    c = 32'h0;
`endif
    return {pc_out, npc_out, if_id_instr, if_id_pc,
            if_id_npc, if_id_valid, misalign, c};
  endfunction

  function automatic logic [193:0] mdl_v();
    logic [31:0] c;
`ifdef FETCH_COUNT_EN
    c = m_cnt;
`else
    c = 32'h0;
`endif
    return {m_pc, m_npc, m_ii, m_ipc, m_inpc,
            m_v, m_mis, c};
  endfunction

  task automatic model_reset();
    m_pc  = 32'h0;
    m_npc = 32'h4;
    m_ii  = 0; m_ipc = 0; m_inpc = 0;
    m_v   = 0; m_mis = 0; m_cnt = 0;
  endtask

  // Drive one cycle of inputs, take one edge, advance model.
  task automatic step(input logic l, input logic [1:0] s,
                      input logic [31:0] bt,
                      input logic [31:0] jt,
                      input logic an, input logic [31:0] ins);
    logic [31:0] nxt;
    le = l; pc_sel = s; branch_target = bt;
    jmpl_target = jt; annul = an; instr_in = ins;
    @(posedge clk);
    if (l) begin
      if (s == 2'd1)      nxt = bt & ~32'd3;
      else if (s == 2'd2) nxt = jt & ~32'd3;
      else                nxt = m_npc + 32'd4;
      m_mis  = (s == 2'd1 && bt[1:0] != 0) ||
               (s == 2'd2 && jt[1:0] != 0);
      m_ipc  = m_pc;
      m_inpc = m_npc;
      m_ii   = an ? 32'h0 : ins;
      m_v    = !an;
      if (!an) m_cnt = m_cnt + 1;
      m_pc   = m_npc;
      m_npc  = nxt;
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    #1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    le = 0; pc_sel = 0; branch_target = 0;
    jmpl_target = 0; annul = 0; instr_in = 0;
    reset = 1'b1;
    model_reset();
    #2;
    tests++;
    if (dut_v() !== mdl_v()) begin
      fails++;
      $display("FAIL reset got=%h exp=%h", dut_v(), mdl_v());
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_sequential();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1, 2'd0, 0, 0, 0, 32'hA0 + m_pc);
      tests++;
      if (dut_v() !== mdl_v() || if_id_valid !== 1'b1) begin
        fails++;
        $display("FAIL seq%0d got=%h exp=%h", i,
                 dut_v(), mdl_v());
      end
    end
    tests++;
    if (pc_out !== 32'd16 || if_id_instr !== 32'hAC) begin
      fails++;
      $display("FAIL seq_end pc=%h ii=%h exp 10/AC",
               pc_out, if_id_instr);
    end
  endtask

  task automatic test_branch();
    do_reset();
    step(1, 2'd0, 0, 0, 0, 32'hA0);
    step(1, 2'd0, 0, 0, 0, 32'hA4);
    step(1, 2'd1, 32'h100, 0, 0, 32'hA8);
    tests++;
    if (pc_out !== 32'd12 || npc_out !== 32'h100 ||
        dut_v() !== mdl_v()) begin
      fails++;
      $display("FAIL branch pc=%h npc=%h exp c/100",
               pc_out, npc_out);
    end
    step(1, 2'd0, 0, 0, 0, 32'hAC);
    tests++;
    if (pc_out !== 32'h100 || npc_out !== 32'h104 ||
        dut_v() !== mdl_v()) begin
      fails++;
      $display("FAIL branch2 pc=%h npc=%h exp 100/104",
               pc_out, npc_out);
    end
  endtask

  task automatic test_jmpl_misalign();
    step(1, 2'd2, 0, 32'h203, 0, 32'h11);
    tests++;
    if (npc_out !== 32'h200 || misalign !== 1'b1 ||
        dut_v() !== mdl_v()) begin
      fails++;
      $display("FAIL jmpl npc=%h mis=%b exp 200/1",
               npc_out, misalign);
    end
    step(1, 2'd0, 0, 32'h203, 0, 32'h12);
    tests++;
    if (misalign !== 1'b0 || dut_v() !== mdl_v()) begin
      fails++;
      $display("FAIL jmpl_clr mis=%b exp 0", misalign);
    end
  endtask

  task automatic test_annul();
    logic [31:0] c0, p0;
    step(1, 2'd1, 32'h400, 0, 0, 32'h55);
    c0 = m_cnt;
    p0 = m_pc;
    step(1, 2'd0, 0, 0, 1, 32'h8200_0001);
    tests++;
    if (if_id_instr !== 32'h0 || if_id_valid !== 1'b0 ||
        if_id_pc !== p0 || m_cnt !== c0 ||
        dut_v() !== mdl_v()) begin
      fails++;
      $display("FAIL annul got=%h exp=%h", dut_v(), mdl_v());
    end
  endtask

  task automatic test_stall();
    logic [193:0] held;
    logic [31:0]  hpc;
    step(1, 2'd0, 0, 0, 0, 32'h77);
    held = mdl_v();
    hpc  = m_pc;
    for (int i = 0; i < 3; i++) begin
      step(0, 2'd1, 32'h900, 32'h0, i[0], 32'hDEAD);
      tests++;
      if (dut_v() !== held) begin
        fails++;
        $display("FAIL stall%0d got=%h exp=%h", i,
                 dut_v(), held);
      end
    end
    step(1, 2'd0, 0, 0, 0, 32'h78);
    tests++;
    if (if_id_pc !== hpc || dut_v() !== mdl_v()) begin
      fails++;
      $display("FAIL resume got=%h exp=%h",
               dut_v(), mdl_v());
    end
  endtask

  task automatic test_wrap();
    step(1, 2'd2, 0, 32'hFFFF_FFF8, 0, 32'h1);
    step(1, 2'd0, 0, 0, 0, 32'h2);
    step(1, 2'd0, 0, 0, 0, 32'h3);
    tests++;
    if (pc_out !== 32'hFFFF_FFFC || npc_out !== 32'h0 ||
        dut_v() !== mdl_v()) begin
      fails++;
      $display("FAIL wrap pc=%h npc=%h exp fffffffc/0",
               pc_out, npc_out);
    end
  endtask

  task automatic test_reset_mid_stall();
    step(1, 2'd0, 0, 0, 0, 32'h5);
    step(0, 2'd0, 0, 0, 0, 32'h6);
    reset = 1'b1;
    model_reset();
    #1;
    tests++;
    if (pc_out !== 32'h0 || npc_out !== 32'h4 ||
        if_id_valid !== 1'b0 || dut_v() !== mdl_v()) begin
      fails++;
      $display("FAIL rst_stall got=%h exp=%h",
               dut_v(), mdl_v());
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_random();
    logic [1:0] s;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        #1;
        reset = 1'b1;
        model_reset();
        #1;
        reset = 1'b0;
      end
      s = 2'($urandom_range(0, 3));
      step($urandom_range(0, 3) != 0, s, $urandom,
           $urandom, $urandom_range(0, 4) == 0, $urandom);
      tests++;
      if (dut_v() !== mdl_v()) begin
        fails++;
        $display("FAIL rand%0d got=%h exp=%h", i,
                 dut_v(), mdl_v());
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    test_reset();
    test_sequential();
    test_branch();
    test_jmpl_misalign();
    test_annul();
    test_stall();
    test_wrap();
    test_reset_mid_stall();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_if_id_stage.md
Name: fetch_if_id_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register directly upstream of control_unit.
- Holds the SPARC PC/nPC pair with delayed-branch semantics and drives the instruction-memory address.
- Latches the fetched word plus its PC/nPC into IF/ID; the IF/ID instruction output feeds control_unit.instr.
- Supports stall (load enable) and annul (delay-slot squash). Squash inserts all-zero words, which control_unit decodes as a bubble with every signal low.

Parameters:
ADDR_W, 32, width of PC, nPC and target addresses
RESET_PC, 32'h0000_0000, PC value after reset; nPC resets to RESET_PC+4

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
le  in  1  load enable; 0 = stall, hold all state
pc_sel  in  2  next-PC source: 00 sequential, 01 branch/call target, 10 jmpl target, 11 reserved (treated as 00)
branch_target  in  ADDR_W  PC-relative target for branch/call, computed in ID
jmpl_target  in  ADDR_W  register-indirect jmpl target, from ALU
annul  in  1  squash the instruction currently being fetched (annulled delay slot)
instr_in  in  32  instruction-memory read data for address pc_out
pc_out  out  ADDR_W  current PC, drives instruction-memory address
npc_out  out  ADDR_W  current nPC
if_id_instr  out  32  IF/ID instruction register, drives control_unit.instr
if_id_pc  out  ADDR_W  PC of the instruction in IF/ID
if_id_npc  out  ADDR_W  nPC of the instruction in IF/ID
if_id_valid  out  1  1 = IF/ID holds a real fetched instruction; 0 = bubble
misalign  out  1  registered; set when the selected target has bits[1:0] != 00

Behaviour:
- Reset (async, any time, including mid-stall):
  - pc_out=RESET_PC, npc_out=RESET_PC+4.
  - if_id_instr=0, if_id_pc=0, if_id_npc=0, if_id_valid=0, misalign=0.
- State machine, 2 states:
  - BOOT: entered on reset. First rising edge with reset low and le=1 loads IF/ID from instr_in, then moves to RUN. if_id_valid is 0 throughout BOOT.
  - RUN: normal operation. Returns to BOOT only on reset.
- Per rising edge with le=1:
  - PC update: pc_out <= npc_out in all cases (delayed branch).
  - nPC update:
    - pc_sel 00/11: npc_out <= npc_out+4, modulo 2^ADDR_W (0xFFFF_FFFC wraps to 0).
    - pc_sel 01: npc_out <= {branch_target[ADDR_W-1:2],2'b00}.
    - pc_sel 10: npc_out <= {jmpl_target[ADDR_W-1:2],2'b00}.
  - IF/ID load: if_id_instr <= instr_in, if_id_pc <= pc_out, if_id_npc <= npc_out, if_id_valid <= 1.
  - annul=1: instead load if_id_instr <= 0 and if_id_valid <= 0; if_id_pc and if_id_npc still load. PC/nPC update is unaffected by annul.
  - misalign <= 1 if pc_sel is 01/10 and the selected target's bits[1:0] != 0; else misalign <= 0.
- le=0: every register holds, including misalign and the FSM state. annul and pc_sel are ignored; upstream re-presents them on the stall-release cycle.
- Latency: instruction at address A appears on if_id_instr exactly one edge after pc_out==A with le=1.
- No combinational path from any input to any output; all outputs are registered.

Optional Feature:
- Macro: FETCH_COUNT_EN.
- Defined:
  - Adds output fetch_count (32 bits), reset to 0.
  - Increments on every edge that loads a valid (non-annulled) instruction into IF/ID.
  - Wraps 0xFFFF_FFFF to 0. Holds during stall.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Shared package sparc_pkg:
  - pc_sel encodings PC_SEQ=2'b00, PC_BRANCH=2'b01, PC_JMPL=2'b10.
  - NOP_INSTR=32'h0.
  - Fetch FSM state enum {BOOT, RUN}.
- One sub-module, pc_npc_register, owning:
  - the PC/nPC pair;
  - the +4 adder;
  - the target mux and alignment masking.
- fetch_if_id_stage instantiates pc_npc_register and owns the FSM, the IF/ID register and the optional counter.

Test Plan:
- Reset, then le=1, pc_sel=00 for 4 edges with instr_in=0xA0 + address → pc_out 0,4,8,12,16; if_id_instr 0xA0,0xA4,0xA8,0xAC; if_id_valid 0 during BOOT, then 1.
- At pc=8 (npc=12): pc_sel=01, branch_target=0x100 → next pc=12 (delay slot), npc=0x100; following edge pc=0x100, npc=0x104.
- pc_sel=10, jmpl_target=0x203 → npc=0x200, misalign=1 on that edge; next sequential edge misalign=0.
- annul=1 on a delay-slot fetch of 0x8200_0001 → if_id_instr=0, if_id_valid=0, if_id_pc correct; fetch_count (when FETCH_COUNT_EN is defined) does not increment.
- le=0 for 3 cycles with pc_sel=01, annul=1 toggling → all outputs frozen; on release the stage resumes from the held PC.
- npc=0xFFFF_FFFC sequential → wraps to 0x0. Assert reset mid-stall → pc_out=0, npc_out=4, if_id_valid=0 immediately, without waiting for a clock edge.
